// File: rtl/sram_req_arbiter_pkg.sv
// Shared definitions for the SRAM request arbiter: FSM state encoding and owner codes.
package sram_req_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam logic OWNER_FETCH = 1'b0;
  localparam logic OWNER_DATA  = 1'b1;

endpackage

// File: rtl/sram_arb_pick.sv
// Winner selection between fetch and data ports, plus next-state of the
// round-robin pointer and the fetch starvation counter.
module sram_arb_pick
  import sram_req_arbiter_pkg::*;
#(
  parameter int unsigned RR_MODE    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic       grant_en,
  input  logic       i_valid,
  input  logic       d_valid,
  input  logic       rr_last_q,
  input  logic [3:0] starve_cnt_q,
  output logic       grant,
  output logic       winner,
  output logic       rr_last_d,
  output logic [3:0] starve_cnt_d
);

  always_comb begin
    grant        = grant_en & (i_valid | d_valid);
    winner       = OWNER_FETCH;
    rr_last_d    = rr_last_q;
    starve_cnt_d = starve_cnt_q;

    if (i_valid && d_valid) begin
      if (RR_MODE != 0) winner = ~rr_last_q;
      else winner = (starve_cnt_q == 4'(STARVE_MAX)) ? OWNER_FETCH : OWNER_DATA;
    end else if (d_valid) begin
      winner = OWNER_DATA;
    end

    // Counter only advances while fetch is actually being held off.
    if (grant) begin
      rr_last_d = winner;
      if (winner == OWNER_FETCH) starve_cnt_d = '0;
      else if (i_valid && (starve_cnt_q != 4'(STARVE_MAX))) starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one external-SRAM request port between instruction fetch and data
// access; one transaction in flight, optional response timeout.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int unsigned RR_MODE    = 1,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_dtr,
  input  logic        d_valid,
  input  logic        d_rw,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_dtw,
  output logic        d_ready,
  output logic [31:0] d_dtr,
  output logic        m_valid,
  output logic        m_rw,
  output logic [31:0] m_addr,
  output logic [31:0] m_dtw,
  input  logic        m_ready,
  input  logic [31:0] m_dtr,
  output logic        owner,
  output logic        busy,
  output logic        tmo_err
);

  state_e      state_q, state_d;
  logic        rr_last_q, rr_last_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic        owner_q, owner_d;
  logic        m_rw_q, m_rw_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_dtw_q, m_dtw_d;
  logic        i_ready_q, i_ready_d;
  logic        d_ready_q, d_ready_d;
  logic [31:0] i_dtr_q, i_dtr_d;
  logic [31:0] d_dtr_q, d_dtr_d;
  logic        tmo_err_q, tmo_err_d;
  logic        grant_en, grant, winner, tmo_expire;
  logic [31:0] resp;

  // No grant during a ready pulse: the completed requester may still hold valid.
  assign grant_en   = (state_q == ST_IDLE) && !i_ready_q && !d_ready_q;
  assign tmo_expire = (TIMEOUT != 0) && (tmo_cnt_q == 8'(TIMEOUT - 1));

  sram_arb_pick #(
    .RR_MODE    (RR_MODE),
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .grant_en     (grant_en),
    .i_valid      (i_valid),
    .d_valid      (d_valid),
    .rr_last_q    (rr_last_q),
    .starve_cnt_q (starve_cnt_q),
    .grant        (grant),
    .winner       (winner),
    .rr_last_d    (rr_last_d),
    .starve_cnt_d (starve_cnt_d)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    m_rw_d    = m_rw_q;
    m_addr_d  = m_addr_q;
    m_dtw_d   = m_dtw_q;
    tmo_cnt_d = '0;
    i_ready_d = 1'b0;
    d_ready_d = 1'b0;
    i_dtr_d   = i_dtr_q;
    d_dtr_d   = d_dtr_q;
    tmo_err_d = tmo_err_q;
    resp      = '0;

    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          owner_d = winner;
          state_d = ST_ISSUE;
          if (winner == OWNER_DATA) begin
            m_rw_d   = d_rw;
            m_addr_d = d_addr;
            m_dtw_d  = d_dtw;
          end else begin
            m_rw_d   = 1'b0;
            m_addr_d = i_addr;
            m_dtw_d  = '0;
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (m_ready || tmo_expire) begin
          state_d = ST_IDLE;
          resp    = m_ready ? m_dtr : '0;
          if (!m_ready) tmo_err_d = 1'b1;
          if (owner_q == OWNER_DATA) begin
            d_ready_d = 1'b1;
            d_dtr_d   = resp;
          end else begin
            i_ready_d = 1'b1;
            i_dtr_d   = resp;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rr_last_q    <= 1'b1;
      starve_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      owner_q      <= 1'b0;
      m_rw_q       <= 1'b0;
      m_addr_q     <= '0;
      m_dtw_q      <= '0;
      i_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
      i_dtr_q      <= '0;
      d_dtr_q      <= '0;
      tmo_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_last_q    <= rr_last_d;
      starve_cnt_q <= starve_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      owner_q      <= owner_d;
      m_rw_q       <= m_rw_d;
      m_addr_q     <= m_addr_d;
      m_dtw_q      <= m_dtw_d;
      i_ready_q    <= i_ready_d;
      d_ready_q    <= d_ready_d;
      i_dtr_q      <= i_dtr_d;
      d_dtr_q      <= d_dtr_d;
      tmo_err_q    <= tmo_err_d;
    end
  end

  assign m_valid = (state_q == ST_ISSUE);
  assign busy    = (state_q != ST_IDLE);
  assign owner   = owner_q;
  assign m_rw    = m_rw_q;
  assign m_addr  = m_addr_q;
  assign m_dtw   = m_dtw_q;
  assign i_ready = i_ready_q;
  assign d_ready = d_ready_q;
  assign i_dtr   = i_dtr_q;
  assign d_dtr   = d_dtr_q;
  assign tmo_err = tmo_err_q;

endmodule
